ds18b20_ctrl: RTL and testbench



---
 rtl/ds18b20_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_ds18b20_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_ctrl.sv
// ds18b20_ctrl
// Periodic 1-Wire master for a single DS18B20. Each cycle it issues Skip ROM +
// Convert T, waits out the conversion, then issues Skip ROM + Read Scratchpad
// and reads the 16-bit temperature word. The word is converted to an unsigned
// magnitude in 0.0001 degC units (saturated to 999999) plus a sign flag, which
// feeds the six-digit display as dd.dddd.
//
// Ports
//   clk    system clock (CLK_DIV cycles per microsecond)
//   rst_n  asynchronous active-low reset; releases dq immediately
//   dq     open-drain 1-Wire bus: driven 0 or Z, external pull-up
//   dout   |temperature| in 0.0001 degC, held between updates
//   sign   1 = negative temperature
//   valid  one-cycle pulse, the cycle after dout/sign update
//   err    presence pulse missing on the last bus reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | 1000 us gap between measurement cycles (also the retry delay)
// RST   | bus reset low 500 us, phase 1
// PRES  | released 500 us, presence sampled at 70 us, phase 1
// WR    | write slots for 0xCC, 0x44
// CONV  | released, wait CONV_MS ms for the conversion
// RST2  | bus reset low 500 us, phase 2
// PRES2 | released 500 us, presence sampled at 70 us, phase 2
// WR2   | write slots for 0xCC, 0xBE
// RD    | 16 read slots, temperature LSB/MSB
// CALC  | convert raw word to dout/sign, back to IDLE

module ds18b20_ctrl #(
    parameter int CLK_DIV = 50,
    parameter int CONV_MS = 750
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         dq,
    output logic [19:0] dout,
    output logic        sign,
    output logic        valid,
    output logic        err
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CONV_US = CONV_MS * 1000;
    localparam int US_MAX  = (CONV_US > 1000) ? CONV_US : 1000;
    localparam int US_W    = $clog2(US_MAX);

    // Terminal counts: a compare against N-1 on a tick means N us have elapsed.
    localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(CLK_DIV - 1);
    localparam logic [US_W-1:0]  IDLE_TC    = US_W'(1000 - 1);
    localparam logic [US_W-1:0]  RST_TC     = US_W'(500 - 1);
    localparam logic [US_W-1:0]  PRES_SMP   = US_W'(70 - 1);
    localparam logic [US_W-1:0]  PRES_TC    = US_W'(500 - 1);
    localparam logic [US_W-1:0]  SLOT_TC    = US_W'(70 - 1);
    localparam logic [US_W-1:0]  WR0_LOW_TC = US_W'(60 - 1);
    localparam logic [US_W-1:0]  WR1_LOW_TC = US_W'(2 - 1);
    localparam logic [US_W-1:0]  RD_LOW_TC  = US_W'(2 - 1);
    localparam logic [US_W-1:0]  RD_SMP     = US_W'(12 - 1);
    localparam logic [US_W-1:0]  CONV_TC    = US_W'(CONV_US - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_PRES, S_WR, S_CONV,
        S_RST2, S_PRES2, S_WR2, S_RD, S_CALC
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [US_W-1:0]   us_cnt;
    logic [3:0]        bit_cnt;
    logic              byte_sel;
    logic              present;
    logic              dq_oe;
    logic              dq_meta;
    logic              dq_s;
    logic [15:0]       raw;
    logic              upd_pend;

    logic              tick;
    logic [7:0]        cmd_byte;
    logic              cmd_bit;
    logic [11:0]       mag;
    logic [21:0]       prod;
    logic [19:0]       dout_calc;

    assign dq   = dq_oe ? 1'b0 : 1'bz;
    assign tick = (div_cnt == DIV_TC);

    always_comb begin
        cmd_byte = 8'hCC;
        if (byte_sel) begin
            cmd_byte = (state == S_WR) ? 8'h44 : 8'hBE;
        end
        cmd_bit = cmd_byte[bit_cnt[2:0]];
        // Only the low 12 bits of the two's complement survive; 0x8000 maps to 0.
        mag       = raw[15] ? (~raw[11:0] + 12'd1) : raw[11:0];
        prod      = {10'd0, mag} * 22'd625;
        dout_calc = (prod > 22'd999999) ? 20'd999999 : prod[19:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            us_cnt   <= '0;
            bit_cnt  <= '0;
            byte_sel <= 1'b0;
            present  <= 1'b0;
            dq_oe    <= 1'b0;
            dq_meta  <= 1'b1;
            dq_s     <= 1'b1;
            raw      <= '0;
            upd_pend <= 1'b0;
            dout     <= '0;
            sign     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            dq_meta  <= dq;
            dq_s     <= dq_meta;
            valid    <= upd_pend;
            upd_pend <= 1'b0;

            if (tick) begin
                div_cnt <= '0;
                us_cnt  <= us_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick && us_cnt == IDLE_TC) begin
                        state  <= S_RST;
                        us_cnt <= '0;
                        dq_oe  <= 1'b1;
                    end
                end

                S_RST, S_RST2: begin
                    if (tick && us_cnt == RST_TC) begin
                        state  <= (state == S_RST) ? S_PRES : S_PRES2;
                        us_cnt <= '0;
                        dq_oe  <= 1'b0;
                    end
                end

                S_PRES, S_PRES2: begin
                    if (tick && us_cnt == PRES_SMP) begin
                        present <= ~dq_s;
                        err     <= dq_s;
                    end
                    if (tick && us_cnt == PRES_TC) begin
                        us_cnt   <= '0;
                        bit_cnt  <= '0;
                        byte_sel <= 1'b0;
                        if (present) begin
                            state <= (state == S_PRES) ? S_WR : S_WR2;
                            dq_oe <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_WR, S_WR2: begin
                    if (tick) begin
                        if (us_cnt == (cmd_bit ? WR1_LOW_TC : WR0_LOW_TC)) begin
                            dq_oe <= 1'b0;
                        end
                        if (us_cnt == SLOT_TC) begin
                            us_cnt <= '0;
                            if (bit_cnt[2:0] == 3'd7) begin
                                bit_cnt <= '0;
                                if (byte_sel) begin
                                    byte_sel <= 1'b0;
                                    state    <= (state == S_WR) ? S_CONV : S_RD;
                                    // Read slots start low; the conversion wait is released.
                                    dq_oe    <= (state == S_WR2);
                                end else begin
                                    byte_sel <= 1'b1;
                                    dq_oe    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                dq_oe   <= 1'b1;
                            end
                        end
                    end
                end

                S_CONV: begin
                    if (tick && us_cnt == CONV_TC) begin
                        state  <= S_RST2;
                        us_cnt <= '0;
                        dq_oe  <= 1'b1;
                    end
                end

                S_RD: begin
                    if (tick) begin
                        if (us_cnt == RD_LOW_TC) begin
                            dq_oe <= 1'b0;
                        end
                        if (us_cnt == RD_SMP) begin
                            raw <= {dq_s, raw[15:1]};
                        end
                        if (us_cnt == SLOT_TC) begin
                            us_cnt <= '0;
                            if (bit_cnt == 4'd15) begin
                                bit_cnt <= '0;
                                state   <= S_CALC;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                dq_oe   <= 1'b1;
                            end
                        end
                    end
                end

                S_CALC: begin
                    dout     <= dout_calc;
                    sign     <= raw[15];
                    upd_pend <= 1'b1;
                    us_cnt   <= '0;
                    state    <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    us_cnt <= '0;
                    dq_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds18b20_ctrl.sv
// Bench for ds18b20_ctrl: behavioural DS18B20 slave plus bus monitor on dq,
// temperature reference computed from integer arithmetic. Runs with a 1 us
// clock and a 1 ms conversion so several full cycles fit in the run.
module tb_ds18b20_ctrl;

    localparam int CLK_P = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    wire         dq;
    logic [19:0] dout;
    logic        sign;
    logic        valid;
    logic        err;

    logic        slave_low = 1'b0;
    pullup (dq);
    assign dq = slave_low ? 1'b0 : 1'bz;

    ds18b20_ctrl #(.CLK_DIV(1), .CONV_MS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dq    (dq),
        .dout  (dout),
        .sign  (sign),
        .valid (valid),
        .err   (err)
    );

    always #(CLK_P / 2) clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_valid = 0;

    logic [15:0] slave_raw = 16'h0000;
    bit          presence_en = 1'b1;
    bit          rd_mode = 1'b0;
    int          rd_cnt = 0;
    int          wbits = 0;
    logic [7:0]  sh = 8'h00;
    logic [7:0]  wr_q[$];
    int          rst_seen = 0;
    longint      t_rel = 0;

    logic [19:0] last_d = 20'd0;
    logic        last_s = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint near(input longint got, input longint exp, input longint tol);
        return ((got >= exp - tol) && (got <= exp + tol)) ? exp : got;
    endfunction

    function automatic longint now_cyc();
        return longint'($time / CLK_P);
    endfunction

    // Temperature in 1/16 degC as a signed integer; magnitude keeps 12 bits.
    function automatic void model(input logic [15:0] r, output logic [19:0] d, output logic s);
        int t;
        int m;
        int p;
        t = int'($signed(r));
        s = (t < 0);
        m = ((t < 0) ? -t : t) % 4096;
        p = m * 625;
        d = 20'((p > 999999) ? 999999 : p);
    endfunction

    always @(negedge clk) if (valid === 1'b1) n_valid++;

    // Slave + monitor: every low pulse is classified as bus reset, read slot or write slot.
    initial begin : slave
        longint t_fall;
        longint w;
        int     n;
        logic   b;
        bit     was_read;
        forever begin
            @(negedge clk);
            while (dq !== 1'b0) @(negedge clk);
            t_fall   = now_cyc();
            was_read = 1'b0;
            if (rd_mode && rd_cnt < 16) begin
                was_read = 1'b1;
                b = slave_raw[rd_cnt];
                rd_cnt++;
                if (!b) begin
                    slave_low = 1'b1;
                    repeat (30) @(negedge clk);
                    slave_low = 1'b0;
                end
            end
            n = 0;
            while (dq !== 1'b1 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) chk("bus_release", dq, 1);
            w = now_cyc() - t_fall;
            if (w >= 400) begin
                chk("rst_low_us", near(w, 500, 1), 500);
                t_rel = now_cyc();
                rst_seen++;
                rd_mode = 1'b0;
                rd_cnt  = 0;
                wbits   = 0;
                if (presence_en) begin
                    repeat (15) @(negedge clk);
                    slave_low = 1'b1;
                    repeat (100) @(negedge clk);
                    slave_low = 1'b0;
                end
            end else if (!was_read) begin
                b = (w < 30);
                chk("wr_low_us", near(w, b ? 2 : 60, 1), b ? 2 : 60);
                sh = {b, sh[7:1]};
                wbits++;
                if (wbits % 8 == 0) begin
                    wr_q.push_back(sh);
                    if (wbits == 16 && sh == 8'hBE) begin
                        rd_mode = 1'b1;
                        rd_cnt  = 0;
                    end
                end
            end
        end
    end

    task automatic do_read(input logic [15:0] r);
        logic [19:0] ed;
        logic        es;
        logic [7:0]  cmd_exp [4];
        bit          hit;
        cmd_exp = '{8'hCC, 8'h44, 8'hCC, 8'hBE};
        slave_raw = r;
        wr_q.delete();
        model(r, ed, es);
        hit = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("valid_seen", hit, 1);
        if (hit) begin
            chk("dout", dout, ed);
            chk("sign", sign, es);
            chk("err_ok", err, 0);
            chk("cmd_count", wr_q.size(), 4);
            for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("cmd_byte", wr_q[i], cmd_exp[i]);
            @(negedge clk);
            chk("valid_1cyc", valid, 0);
            chk("dout_hold", dout, ed);
            last_d = ed;
            last_s = es;
        end
    endtask

    initial begin : main
        logic [15:0] r;
        longint      t0;
        int          nv0;
        int          rs0;
        bit          hit;

        rst_n = 1'b0;
        presence_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_sign", sign, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_dq", dq, 1);
        rst_n = 1'b1;

        do_read(16'h0191);
        do_read(16'hFF5E);
        do_read(16'h07D0);
        do_read(16'h0000);
        do_read(16'h8000);
        r = 16'($urandom);
        do_read(r);

        // Withheld presence: err at 70 us, no valid, retry after the remaining 430 us + idle.
        presence_en = 1'b0;
        nv0 = n_valid;
        rs0 = rst_seen;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst_seen != rs0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("nopres_rst_seen", hit, 1);
        t0 = t_rel;
        while (now_cyc() < t0 + 60) @(negedge clk);
        chk("err_before_sample", err, 0);
        while (now_cyc() < t0 + 75) @(negedge clk);
        chk("err_absent", err, 1);
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dq === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("retry_seen", hit, 1);
        chk("retry_gap_us", near(now_cyc() - t0, 1500, 2), 1500);
        chk("no_valid", n_valid - nv0, 0);
        chk("err_hold_dout", dout, last_d);
        chk("err_hold_sign", sign, last_s);
        presence_en = 1'b1;
        r = 16'($urandom);
        do_read(r);

        // Reset during the 5th read slot while the master holds the bus low.
        slave_raw = 16'h0191;
        hit = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (rd_mode && rd_cnt == 5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("rd5_seen", hit, 1);
        chk("rd5_dq_low", dq, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dq", dq, 1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_sign", sign, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_err", err, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        t0 = now_cyc();
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dq === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("restart_seen", hit, 1);
        chk("idle_wait_us", near(now_cyc() - t0, 1000, 1), 1000);
        r = 16'($urandom);
        do_read(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
